// File: rtl/wt_dcache_mem_banked.sv
// ---------------------------------------------------------------------------
// wt_dcache_mem_banked
//   Data/tag/valid storage, read arbiter and hit logic for the write-through
//   L1 data cache. The storage is organised as NumBanks word-wide banks; way w
//   of bank b holds word b of every line. After reset, and on flush_i, a sweep
//   FSM clears the valid bits of every set, one set per cycle.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               pulse: invalidate all lines
//   flush_busy_o          sweep in progress (all other accesses stalled)
//   rd_req_i/prio/tag_only per-port read request, priority, tag-only lookup
//   rd_idx_i/off_i/tag_i  per-port set index, byte offset, tag (tag is
//                         presented one cycle after the ack)
//   rd_ack_o              one-hot read grant
//   rd_vld_o, rd_port_o   registered response valid and owning port
//   rd_vld_bits_o         valid bits of the read set
//   rd_hit_oh_o           per-way tag hit
//   rd_data_o             word from the lowest hitting way ('0 on miss/tag-only)
//   wr_cl_*               full-line tag/valid/data write (highest priority)
//   wr_req_i, wr_*        single-word write into one way, wr_ack_o on accept
// ---------------------------------------------------------------------------
module wt_dcache_mem_banked #(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned NumWays   = 4,
  parameter int unsigned NumSets   = 256,
  parameter int unsigned LineWidth = 128,
  parameter int unsigned WordWidth = 64,
  parameter int unsigned TagWidth  = 44,
  parameter int unsigned ArbMode   = 0,
  localparam int unsigned IdxW     = $clog2(NumSets),
  localparam int unsigned OffW     = $clog2(LineWidth / 8),
  localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  output logic                          flush_busy_o,
  input  logic [NumPorts-1:0]           rd_req_i,
  input  logic [NumPorts-1:0]           rd_prio_i,
  input  logic [NumPorts-1:0]           rd_tag_only_i,
  input  logic [NumPorts*IdxW-1:0]      rd_idx_i,
  input  logic [NumPorts*OffW-1:0]      rd_off_i,
  input  logic [NumPorts*TagWidth-1:0]  rd_tag_i,
  output logic [NumPorts-1:0]           rd_ack_o,
  output logic                          rd_vld_o,
  output logic [PortW-1:0]              rd_port_o,
  output logic [NumWays-1:0]            rd_vld_bits_o,
  output logic [NumWays-1:0]            rd_hit_oh_o,
  output logic [WordWidth-1:0]          rd_data_o,
  input  logic                          wr_cl_vld_i,
  input  logic [NumWays-1:0]            wr_cl_we_i,
  input  logic [IdxW-1:0]               wr_cl_idx_i,
  input  logic [TagWidth-1:0]           wr_cl_tag_i,
  input  logic                          wr_cl_vbit_i,
  input  logic [LineWidth-1:0]          wr_cl_data_i,
  input  logic [LineWidth/8-1:0]        wr_cl_be_i,
  input  logic [NumWays-1:0]            wr_req_i,
  input  logic [IdxW-1:0]               wr_idx_i,
  input  logic [OffW-1:0]               wr_off_i,
  input  logic [WordWidth-1:0]          wr_data_i,
  input  logic [WordWidth/8-1:0]        wr_be_i,
  output logic                          wr_ack_o
);

  localparam int unsigned NumBanks  = LineWidth / WordWidth;
  localparam int unsigned WordBytes = WordWidth / 8;
  localparam int unsigned WOffW     = $clog2(WordBytes);
  localparam int unsigned BankW     = (NumBanks > 1) ? $clog2(NumBanks) : 1;

  typedef enum logic {SWEEP, IDLE} state_e;

  // Bank select is the offset bits above the in-word byte offset. With a
  // single bank the shift leaves zero, so no special case is needed.
  function automatic logic [BankW-1:0] bank_of(input logic [OffW-1:0] off);
    return BankW'(off >> WOffW);
  endfunction

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic              sweeping;

  assign sweeping     = (state_q == SWEEP);
  assign flush_busy_o = sweeping;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IdxW'(NumSets - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        // flush_i is only looked at here, so a flush during a sweep is ignored.
        if (flush_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read arbitration
  // ---------------------------------------------------------------------------
  logic [NumPorts-1:0] req_vec;
  logic                gnt_found;
  logic [PortW-1:0]    gnt_port;
  logic [PortW:0]      cand;
  logic [PortW:0]      rr_nxt;
  logic [PortW-1:0]    rr_q, rr_d;
  logic                rd_en;
  logic [IdxW-1:0]     g_idx;
  logic [OffW-1:0]     g_off;
  logic                g_tag_only;
  logic [BankW-1:0]    rd_bank, wr_bank;
  logic                wr_cl_en;

  always_comb begin
    // High-priority requests, when present, shadow all others.
    req_vec = rd_req_i;
    if (|(rd_req_i & rd_prio_i)) req_vec = rd_req_i & rd_prio_i;

    gnt_found = 1'b0;
    gnt_port  = '0;
    cand      = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (ArbMode == 0) begin
        // Round-robin: search starts at rr_q and wraps.
        cand = {1'b0, rr_q} + (PortW+1)'(i);
        if (cand >= (PortW+1)'(NumPorts)) cand = cand - (PortW+1)'(NumPorts);
      end else begin
        cand = (PortW+1)'(i);
      end
      if (!gnt_found && req_vec[cand[PortW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_port  = cand[PortW-1:0];
      end
    end

    g_idx      = '0;
    g_off      = '0;
    g_tag_only = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      if (gnt_port == PortW'(k)) begin
        g_idx      = rd_idx_i[k*IdxW +: IdxW];
        g_off      = rd_off_i[k*OffW +: OffW];
        g_tag_only = rd_tag_only_i[k];
      end
    end

    // A line write owns the arrays for the cycle; the sweep blocks everything.
    rd_en    = gnt_found & ~sweeping & ~wr_cl_vld_i;
    rd_ack_o = '0;
    if (rd_en) rd_ack_o[gnt_port] = 1'b1;

    rr_nxt = {1'b0, gnt_port} + 1'b1;
    rr_d   = rr_q;
    if (rd_en) rr_d = (rr_nxt == (PortW+1)'(NumPorts)) ? '0 : rr_nxt[PortW-1:0];
  end

  assign rd_bank  = bank_of(g_off);
  assign wr_bank  = bank_of(wr_off_i);
  assign wr_cl_en = wr_cl_vld_i & ~sweeping;

  // Word write yields only to a data read of the same bank; tag-only reads
  // never touch the data banks.
  assign wr_ack_o = (|wr_req_i) & ~sweeping & ~wr_cl_vld_i &
                    ~(rd_en & ~g_tag_only & (rd_bank == wr_bank));

  // ---------------------------------------------------------------------------
  // Storage arrays
  // ---------------------------------------------------------------------------
  logic [TagWidth-1:0]  tag_mem  [NumSets][NumWays];
  logic [NumWays-1:0]   vld_mem  [NumSets];
  logic [WordWidth-1:0] data_mem [NumBanks][NumWays][NumSets];

  // NOTE: the arrays are SRAM models and carry no reset; the valid bits are
  // cleared by the sweep that always follows reset.
  always_ff @(posedge clk_i) begin
    if (sweeping) begin
      vld_mem[cnt_q] <= '0;
    end else if (wr_cl_en) begin
      for (int w = 0; w < NumWays; w++) begin
        if (wr_cl_we_i[w]) begin
          vld_mem[wr_cl_idx_i][w] <= wr_cl_vbit_i;
          tag_mem[wr_cl_idx_i][w] <= wr_cl_tag_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      for (int w = 0; w < NumWays; w++) begin
        for (int k = 0; k < WordBytes; k++) begin
          if (wr_cl_en && wr_cl_we_i[w] && wr_cl_be_i[b*WordBytes + k]) begin
            data_mem[b][w][wr_cl_idx_i][8*k +: 8] <= wr_cl_data_i[b*WordWidth + 8*k +: 8];
          end
          if (wr_ack_o && wr_req_i[w] && (wr_bank == BankW'(b)) && wr_be_i[k]) begin
            data_mem[b][w][wr_idx_i][8*k +: 8] <= wr_data_i[8*k +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read response
  // ---------------------------------------------------------------------------
  logic                 rsp_vld_q;
  logic [PortW-1:0]     rsp_port_q;
  logic [NumWays-1:0]   rsp_vbits_q;
  logic                 rsp_tag_only_q;
  logic [TagWidth-1:0]  rsp_tag_q  [NumWays];
  logic [WordWidth-1:0] rsp_data_q [NumWays];
  logic [TagWidth-1:0]  cmp_tag;
  logic                 data_found;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= SWEEP;
      cnt_q          <= '0;
      rr_q           <= '0;
      rsp_vld_q      <= 1'b0;
      rsp_port_q     <= '0;
      rsp_vbits_q    <= '0;
      rsp_tag_only_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      rsp_vld_q <= rd_en;
      if (rd_en) begin
        rsp_port_q     <= gnt_port;
        rsp_vbits_q    <= vld_mem[g_idx];
        rsp_tag_only_q <= g_tag_only;
      end
    end
  end

  // Captured tags and data words are only observed through rsp_vld_q.
  always_ff @(posedge clk_i) begin
    if (rd_en) begin
      for (int w = 0; w < NumWays; w++) begin
        rsp_tag_q[w]  <= tag_mem[g_idx][w];
        rsp_data_q[w] <= data_mem[rd_bank][w][g_idx];
      end
    end
  end

  always_comb begin
    // The compare tag arrives the cycle after the ack, from the owning port.
    cmp_tag = '0;
    for (int k = 0; k < NumPorts; k++) begin
      if (rsp_port_q == PortW'(k)) cmp_tag = rd_tag_i[k*TagWidth +: TagWidth];
    end

    rd_hit_oh_o = '0;
    rd_data_o   = '0;
    data_found  = 1'b0;
    for (int w = 0; w < NumWays; w++) begin
      rd_hit_oh_o[w] = rsp_vld_q & rsp_vbits_q[w] & (rsp_tag_q[w] == cmp_tag);
      // Lowest hitting way supplies the data.
      if (rd_hit_oh_o[w] && !data_found && !rsp_tag_only_q) begin
        rd_data_o  = rsp_data_q[w];
        data_found = 1'b1;
      end
    end
  end

  assign rd_vld_o      = rsp_vld_q;
  assign rd_port_o     = rsp_port_q;
  assign rd_vld_bits_o = rsp_vld_q ? rsp_vbits_q : '0;

endmodule

// File: tb/tb_wt_dcache_mem_banked.sv
// ---------------------------------------------------------------------------
// tb_wt_dcache_mem_banked
//   Directed bench for wt_dcache_mem_banked with default parameters
//   (3 ports, 4 ways, 256 sets, 2 banks of 64 bits, round-robin).
//   Inputs are driven 1 time unit after the rising edge, outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_wt_dcache_mem_banked;

  localparam int NP = 3;
  localparam int NW = 4;
  localparam int IW = 8;
  localparam int OW = 4;
  localparam int TW = 44;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              flush_busy;
  logic [NP-1:0]     rd_req, rd_prio, rd_tag_only;
  logic [NP*IW-1:0]  rd_idx;
  logic [NP*OW-1:0]  rd_off;
  logic [NP*TW-1:0]  rd_tag;
  logic [NP-1:0]     rd_ack;
  logic              rd_vld;
  logic [1:0]        rd_port;
  logic [NW-1:0]     rd_vld_bits, rd_hit_oh;
  logic [63:0]       rd_data;
  logic              wr_cl_vld, wr_cl_vbit;
  logic [NW-1:0]     wr_cl_we;
  logic [IW-1:0]     wr_cl_idx;
  logic [TW-1:0]     wr_cl_tag;
  logic [127:0]      wr_cl_data;
  logic [15:0]       wr_cl_be;
  logic [NW-1:0]     wr_req;
  logic [IW-1:0]     wr_idx;
  logic [OW-1:0]     wr_off;
  logic [63:0]       wr_data;
  logic [7:0]        wr_be;
  logic              wr_ack;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wt_dcache_mem_banked dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .flush_busy_o  (flush_busy),
    .rd_req_i      (rd_req),
    .rd_prio_i     (rd_prio),
    .rd_tag_only_i (rd_tag_only),
    .rd_idx_i      (rd_idx),
    .rd_off_i      (rd_off),
    .rd_tag_i      (rd_tag),
    .rd_ack_o      (rd_ack),
    .rd_vld_o      (rd_vld),
    .rd_port_o     (rd_port),
    .rd_vld_bits_o (rd_vld_bits),
    .rd_hit_oh_o   (rd_hit_oh),
    .rd_data_o     (rd_data),
    .wr_cl_vld_i   (wr_cl_vld),
    .wr_cl_we_i    (wr_cl_we),
    .wr_cl_idx_i   (wr_cl_idx),
    .wr_cl_tag_i   (wr_cl_tag),
    .wr_cl_vbit_i  (wr_cl_vbit),
    .wr_cl_data_i  (wr_cl_data),
    .wr_cl_be_i    (wr_cl_be),
    .wr_req_i      (wr_req),
    .wr_idx_i      (wr_idx),
    .wr_off_i      (wr_off),
    .wr_data_i     (wr_data),
    .wr_be_i       (wr_be),
    .wr_ack_o      (wr_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; rd_req = '0; rd_prio = '0; rd_tag_only = '0;
    rd_idx = '0; rd_off = '0; rd_tag = '0;
    wr_cl_vld = 0; wr_cl_we = '0; wr_cl_idx = '0; wr_cl_tag = '0;
    wr_cl_vbit = 0; wr_cl_data = '0; wr_cl_be = '0;
    wr_req = '0; wr_idx = '0; wr_off = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic set_rd(input int p, input logic [IW-1:0] idx, input logic [OW-1:0] off,
                        input logic tag_only);
    rd_req[p]          = 1'b1;
    rd_idx[p*IW +: IW] = idx;
    rd_off[p*OW +: OW] = off;
    rd_tag_only[p]     = tag_only;
  endtask

  task automatic wr_line(input logic [NW-1:0] we, input logic [IW-1:0] idx,
                         input logic [TW-1:0] tag, input logic [127:0] data);
    wr_cl_vld = 1; wr_cl_we = we; wr_cl_idx = idx; wr_cl_tag = tag;
    wr_cl_vbit = 1; wr_cl_data = data; wr_cl_be = '1;
  endtask

  // Counts falling edges with flush_busy high. mode 1 pulses flush_i at
  // cnt 50 (must be ignored); mode 2 asserts reset at cnt 100 and restarts
  // the count once reset is released. Returns at a falling edge with busy low.
  task automatic count_sweep(input int mode, output int n, output int ack_seen);
    bit did_rst;
    did_rst  = 0;
    n        = 0;
    ack_seen = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (!flush_busy) break;
      if (rd_ack != '0) ack_seen++;
      flush = (mode == 1 && n == 50);
      if (mode == 2 && !did_rst && n == 100) begin
        rst = 1;
        @(posedge clk);
        #1;
        rst     = 0;
        did_rst = 1;
        n       = 0;
        continue;
      end
      n++;
    end
    flush = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks;
    clear_inputs();
    rst = 1;
    // Requests during reset must not be acked.
    rd_req = '1;
    wr_req = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(flush_busy), 64'd1);
    check("rst_rd_ack", 64'(rd_ack), 64'd0);
    check("rst_wr_ack", 64'(wr_ack), 64'd0);
    check("rst_rd_vld", 64'(rd_vld), 64'd0);
    check("rst_hit", 64'(rd_hit_oh), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;

    // Initial sweep: exactly 256 busy cycles, no acks.
    count_sweep(0, n, acks);
    rd_req = '0;
    wr_req = '0;
    check("sweep_len", 64'(n), 64'd256);
    check("sweep_no_ack", 64'(acks), 64'd0);
    tick();

    // Round-robin with all three ports requesting (tag-only, set 0).
    for (int p = 0; p < NP; p++) set_rd(p, 8'd0, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_ack", 64'(rd_ack), 64'(3'b001 << (i % 3)));
      if (i > 0) begin
        check("rr_vld", 64'(rd_vld), 64'd1);
        check("rr_port", 64'(rd_port), 64'((i - 1) % 3));
      end
      tick();
    end
    // High-priority port 2 is granted every cycle.
    rd_prio = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("prio_ack", 64'(rd_ack), 64'b100);
      tick();
    end
    clear_inputs();
    @(negedge clk);
    check("prio_rsp_port", 64'(rd_port), 64'd2);
    check("sweep_vbits", 64'(rd_vld_bits), 64'd0);
    tick();

    // Line write to way 2 of set 5 blocks a concurrent read and word write.
    wr_line(4'b0100, 8'd5, 44'h1A, {64'hB, 64'hA});
    set_rd(0, 8'd5, 4'd8, 1'b0);
    wr_req = 4'b0001; wr_idx = 8'd9; wr_off = 4'd0; wr_be = '1;
    @(negedge clk);
    check("wrcl_blocks_rd", 64'(rd_ack), 64'd0);
    check("wrcl_blocks_wr", 64'(wr_ack), 64'd0);
    tick();
    wr_cl_vld = 0; wr_req = '0;
    @(negedge clk);
    check("rd5_ack", 64'(rd_ack), 64'b001);
    tick();
    rd_req = '0;
    rd_tag[0 +: TW] = 44'h1A;
    @(negedge clk);
    check("rd5_vld", 64'(rd_vld), 64'd1);
    check("rd5_hit", 64'(rd_hit_oh), 64'b0100);
    check("rd5_vbits", 64'(rd_vld_bits), 64'b0100);
    check("rd5_data", rd_data, 64'hB);
    tick();

    // Set 7, way 0: tag 0x22, bank0 = 1111.., bank1 = CCCC..
    wr_line(4'b0001, 8'd7, 44'h22, {64'hCCCC_CCCC_CCCC_CCCC, 64'h1111_1111_1111_1111});
    tick();
    wr_cl_vld = 0;

    // Data read of bank 0 collides with a bank-0 word write: write stalls.
    set_rd(0, 8'd5, 4'd0, 1'b0);
    wr_req = 4'b0001; wr_idx = 8'd7; wr_off = 4'd0; wr_be = '1;
    wr_data = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    check("coll_rd_ack", 64'(rd_ack), 64'b001);
    check("coll_wr_ack", 64'(wr_ack), 64'd0);
    tick();
    // Same read again with a bank-1 word write: both proceed.
    wr_off = 4'd8; wr_data = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    check("prev_rd_data", rd_data, 64'hA);
    check("nocoll_rd_ack", 64'(rd_ack), 64'b001);
    check("nocoll_wr_ack", 64'(wr_ack), 64'd1);
    tick();
    // Read-after-write: set 7 bank 1 acked the cycle after the write.
    wr_req = '0;
    set_rd(0, 8'd7, 4'd8, 1'b0);
    @(negedge clk);
    check("raw_ack", 64'(rd_ack), 64'b001);
    tick();
    rd_tag[0 +: TW] = 44'h22;
    set_rd(0, 8'd7, 4'd0, 1'b0);
    @(negedge clk);
    check("raw_hit", 64'(rd_hit_oh), 64'b0001);
    check("raw_data", rd_data, 64'hCAFE_F00D_1234_5678);
    tick();
    rd_req = '0;
    @(negedge clk);
    check("blocked_wr_untouched", rd_data, 64'h1111_1111_1111_1111);
    tick();

    // Tag-only read of bank 0 does not block a bank-0 word write (partial BE).
    set_rd(0, 8'd7, 4'd0, 1'b1);
    wr_req = 4'b0001; wr_idx = 8'd7; wr_off = 4'd0; wr_be = 8'h0F;
    wr_data = 64'h0000_0000_5555_5555;
    @(negedge clk);
    check("tagonly_rd_ack", 64'(rd_ack), 64'b001);
    check("tagonly_wr_ack", 64'(wr_ack), 64'd1);
    tick();
    wr_req = '0;
    set_rd(0, 8'd7, 4'd0, 1'b0);
    @(negedge clk);
    check("tagonly_hit", 64'(rd_hit_oh), 64'b0001);
    check("tagonly_data", rd_data, 64'd0);
    tick();
    rd_req = '0;
    @(negedge clk);
    check("partial_be_data", rd_data, 64'h1111_1111_5555_5555);
    tick();

    // Multi-hit in set 5 (ways 0, 2, 3): lowest way supplies the data.
    wr_line(4'b1001, 8'd5, 44'h1A, {64'hE, 64'hD});
    tick();
    wr_cl_vld = 0;
    set_rd(0, 8'd5, 4'd8, 1'b0);
    tick();
    rd_req = '0;
    rd_tag[0 +: TW] = 44'h1A;
    @(negedge clk);
    check("multi_hit", 64'(rd_hit_oh), 64'b1101);
    check("multi_data", rd_data, 64'hE);
    tick();
    // Tag miss in a valid set.
    set_rd(0, 8'd5, 4'd8, 1'b0);
    tick();
    rd_req = '0;
    rd_tag[0 +: TW] = 44'h1B;
    @(negedge clk);
    check("miss_hit", 64'(rd_hit_oh), 64'd0);
    check("miss_data", rd_data, 64'd0);
    check("miss_vbits", 64'(rd_vld_bits), 64'b1101);
    tick();

    // Flush: full sweep, a second flush mid-sweep is ignored. Port 1 keeps
    // requesting set 5 and must only be acked once the sweep is over.
    flush = 1;
    tick();
    flush = 0;
    set_rd(1, 8'd5, 4'd8, 1'b0);
    rd_tag[1*TW +: TW] = 44'h1A;
    count_sweep(1, n, acks);
    check("flush_len", 64'(n), 64'd256);
    check("flush_no_ack", 64'(acks), 64'd0);
    check("post_flush_ack", 64'(rd_ack), 64'b010);
    tick();
    rd_req = '0;
    @(negedge clk);
    check("post_flush_port", 64'(rd_port), 64'd1);
    check("post_flush_hit", 64'(rd_hit_oh), 64'd0);
    check("post_flush_vbits", 64'(rd_vld_bits), 64'd0);
    tick();

    // Reset at cnt 100 restarts a full-length sweep.
    flush = 1;
    tick();
    flush = 0;
    count_sweep(2, n, acks);
    check("rst_mid_sweep_len", 64'(n), 64'd256);
    check("rst_mid_rd_vld", 64'(rd_vld), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
